// File: rtl/pattern_tx_pkg.sv
// Shared types and constants for the pattern transmitter.
// The inter-frame gap is built only when PATTERN_TX_GAP_EN is defined.
package pattern_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      LAST  = 2'd3
   } state_t;

   localparam logic [4:0] DEFAULT_PATTERN = 5'b11011;

   // Smallest width able to hold the values 0..n-1 (never narrower than 1 bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pattern_tx_shifter.sv
// Loadable MSB-first shift register with a bit counter and a registered last-bit flag.
// bit_out is the bit currently presented; clr zeroes everything so the line idles low.
module pattern_tx_shifter
   import pattern_tx_pkg::*;
#(
   parameter int PAT_W = 5
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic             shift,
   input  logic [PAT_W-1:0] load_val,
   output logic             bit_out,
   output logic             last_bit
);

   localparam int IDX_W = idx_width(PAT_W);

   logic [PAT_W-1:0] sr;
   logic [IDX_W-1:0] bit_idx;
   logic             last_q;

   // Priority clr > load > shift; last_q is high while bit_idx==0 is on the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr      <= '0;
         bit_idx <= '0;
         last_q  <= 1'b0;
      end else if (clr) begin
         sr      <= '0;
         bit_idx <= '0;
         last_q  <= 1'b0;
      end else if (load) begin
         sr      <= load_val;
         bit_idx <= IDX_W'(PAT_W - 1);
         last_q  <= (PAT_W == 1);
      end else if (shift) begin
         sr      <= sr << 1;
         bit_idx <= bit_idx - IDX_W'(1);
         last_q  <= (bit_idx == IDX_W'(1));
      end
   end

   assign bit_out  = sr[PAT_W-1];
   assign last_bit = last_q;

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends pattern_in MSB first, repeat_n frames, with abort.
// Define PATTERN_TX_GAP_EN to insert GAP_LEN idle cycles between frames.
module pattern_tx
   import pattern_tx_pkg::*;
#(
   parameter int PAT_W   = 5,
   parameter int CNT_W   = 4,
   parameter int GAP_LEN = 2
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [PAT_W-1:0] pattern_in,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic             abort,
   output logic             data,
   output logic             data_vld,
   output logic             frame_done,
   output logic             busy,
   output state_t           fsm_state
);

   // Handshake: a request is taken on a rising edge where start_valid && start_ready;
   // start_ready is high only in IDLE, and start_valid outside IDLE has no effect.

`ifdef PATTERN_TX_GAP_EN
   localparam bit GAP_EN = 1'b1;
   localparam int GAP_W  = idx_width(GAP_LEN);
   logic [GAP_W-1:0] gap_cnt;
`else
   localparam bit GAP_EN = 1'b0;
`endif

   state_t           state;
   logic [PAT_W-1:0] pat_q;
   logic [CNT_W-1:0] frames_left;
   logic             hs;
   logic             more;
   logic             sh_clr;
   logic             sh_load;
   logic             sh_shift;
   logic [PAT_W-1:0] sh_val;
   logic             sh_last;

   assign start_ready = (state == IDLE);
   assign busy        = (state != IDLE);
   assign fsm_state   = state;
   assign hs          = start_valid && start_ready;
   assign more        = (frames_left > CNT_W'(1));

   always_comb begin
      sh_clr   = 1'b0;
      sh_load  = 1'b0;
      sh_shift = 1'b0;
      sh_val   = pat_q;
      case (state)
         IDLE: begin
            if (hs) begin
               sh_load = 1'b1;
               sh_val  = pattern_in;
            end
         end
         SHIFT: begin
            if (abort)              sh_clr   = 1'b1;
            else if (!sh_last)      sh_shift = 1'b1;
            else if (more && !GAP_EN) sh_load = 1'b1;
            else                    sh_clr   = 1'b1;
         end
`ifdef PATTERN_TX_GAP_EN
         GAP: begin
            if (abort)                   sh_clr  = 1'b1;
            else if (gap_cnt == '0)      sh_load = 1'b1;
         end
`endif
         default: sh_clr = 1'b1;
      endcase
   end

   pattern_tx_shifter #(
      .PAT_W (PAT_W)
   ) u_shifter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (sh_clr),
      .load     (sh_load),
      .shift    (sh_shift),
      .load_val (sh_val),
      .bit_out  (data),
      .last_bit (sh_last)
   );

   assign frame_done = sh_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         data_vld    <= 1'b0;
         pat_q       <= '0;
         frames_left <= '0;
`ifdef PATTERN_TX_GAP_EN
         gap_cnt     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (hs) begin
                  state       <= SHIFT;
                  data_vld    <= 1'b1;
                  pat_q       <= pattern_in;
                  frames_left <= (repeat_n == '0) ? CNT_W'(1) : repeat_n;
               end
            end
            SHIFT: begin
               if (abort) begin
                  state       <= IDLE;
                  data_vld    <= 1'b0;
                  frames_left <= '0;
               end else if (sh_last) begin
                  frames_left <= frames_left - CNT_W'(1);
                  if (more) begin
`ifdef PATTERN_TX_GAP_EN
                     state    <= GAP;
                     data_vld <= 1'b0;
                     gap_cnt  <= GAP_W'(GAP_LEN - 1);
`else
                     data_vld <= 1'b1;
`endif
                  end else begin
                     state    <= LAST;
                     data_vld <= 1'b0;
                  end
               end
            end
`ifdef PATTERN_TX_GAP_EN
            GAP: begin
               if (abort) begin
                  state       <= IDLE;
                  data_vld    <= 1'b0;
                  frames_left <= '0;
                  gap_cnt     <= '0;
               end else if (gap_cnt == '0) begin
                  state    <= SHIFT;
                  data_vld <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
`endif
            LAST: begin
               state    <= IDLE;
               data_vld <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               data_vld <= 1'b0;
            end
         endcase
      end
   end

endmodule
